decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised successor of the MIPS-32 instruction-decode stage. Decodes the instruction, reads the register file, extends the immediate and builds the jump target.
- Registers everything into the ID/EX pipeline register.
- Adds what the old stage lacks:
  - async active-low reset;
  - write-first register-file bypass;
  - load-use hazard detection with bubble insertion;
  - flush and hold control;
  - a valid bit;
  - zero-extension for logical immediates.
- Sits between the IF/ID buffer and the execute stage.

Parameters:
- DATA_W, 32: datapath and register width (≥32).
- REG_ADDR_W, 5: register address width; the register file has 2**REG_ADDR_W entries.
- ZERO_EXT_LOGIC, 1: when 1, opcodes 0x0C/0x0D/0x0E (andi/ori/xori) zero-extend the immediate.

Ports:
- clk  in  1  stage clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  32  instruction from IF/ID.
- valid_in  in  1  instr_in is a real instruction.
- adder_in  in  DATA_W  PC+4 from IF/ID.
- reg_write  in  1  writeback enable.
- address_write  in  REG_ADDR_W  writeback register.
- data_write  in  DATA_W  writeback data.
- flush  in  1  branch/jump taken: squash the instruction entering ID/EX.
- hold  in  1  downstream stall: freeze ID/EX.
- stall_out  out  1  combinational: IF and IF/ID must hold.
- valid_out  out  1  ID/EX holds a real instruction.
- dato1, dato2  out  DATA_W  registered rs/rt values.
- immediate  out  DATA_W  registered extended immediate.
- adder_out  out  DATA_W  registered PC+4.
- rt_out, rd_out  out  REG_ADDR_W  registered rt/rd (instr[20:16], instr[15:11], zero-padded/truncated to REG_ADDR_W).
- ex_salida 2, m_salida 3, wb_salida 3, aluop_salida 4, funct_out 6  out  registered control fields.
- jump_address_out  out  DATA_W  registered {adder_in[DATA_W-1:28], instr[25:0], 2'b00}.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous, active-low.
  - On reset, every registered output is 0, valid_out=0, and all register-file entries are 0.
  - Reset mid-operation discards the in-flight ID/EX contents immediately.
  - Release is synchronous to the next posedge.
- Register file:
  - Register 0 reads 0; writes to 0 are ignored.
  - Writes occur on posedge when reg_write=1.
  - Reads are combinational and write-first: if reg_write and address_write==read address≠0, the read returns data_write the same cycle.
- Control: the opcode drives the control sub-block, using the existing EX/M/WB/ALUop encoding.
  - M[1] = MemRead.
  - Opcode not in table → all control 0.
- Immediate:
  - Sign-extend instr[15:0] to DATA_W.
  - Zero-extend instead for the logical opcodes when ZERO_EXT_LOGIC=1.
- Hazard (combinational): hazard = valid_out & m_salida[1] & rt_out≠0 & valid_in & (rt_out==instr[25:21] | rt_out==instr[20:16]).
- stall_out = hazard & ~flush & ~hold.
  - hold is propagated externally, not via stall_out.
- ID/EX update per posedge, in priority order:
  1. flush → bubble: all control, valid_out=0; data fields don't-care, driven 0.
  2. hold → all outputs keep their value.
  3. hazard → bubble, as in 1.
  4. Otherwise load: decoded values, with valid_out=valid_in.
  - valid_in=0 loads a bubble.
- Latency: instr_in to outputs is 1 cycle. A load-use pair costs exactly 1 bubble.
- Simultaneous cases:
  - flush & hazard → flush wins, stall_out=0.
  - hold & hazard → hold wins, stall_out=0.
  - A writeback to the register being read in the same cycle is bypassed.
  - A write to reg 0 has no effect.

Decomposition:
- Package decode_pkg holds:
  - control field widths;
  - the M_MEMREAD bit index (1);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ANDI, OP_ORI, OP_XORI;
  - a bubble-constant function.
- One natural sub-module: regfile_bypass, the parametrised register file with write-first read and async reset.
- The control decode stays a function in the package.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid_out=1 → all outputs 0 immediately. After release, reading r5 → dato1=0.
- Bypass and reg 0:
  - Write r9=0xDEADBEEF in the same cycle as decoding "add r3,r9,r0" → next cycle dato1=0xDEADBEEF, dato2=0.
  - Writing r0 has no effect.
- Load-use:
  - Cycle n: lw r8,4(r1). Cycle n+1: add r2,r8,r4 → stall_out=1 in n+1.
  - At n+2, valid_out=0 with zero control.
  - At n+3, the add appears with valid_out=1.
- Flush priority: load-use condition plus flush=1 → stall_out=0, next cycle valid_out=0.
- Hold: hold=1 for 3 cycles with changing instr_in → all outputs stable. Release → the next instruction loads.
- Immediates:
  - addi with imm 0xFFFF → immediate=0xFFFFFFFF.
  - ori with 0xFFFF → 0x0000FFFF.
  - j 0x0100000 with adder_in=0x40000004 → jump_address_out=0x40400000.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: control field widths, opcode constants and the control decode for the ID stage
package decode_pkg;
  localparam int EX_W      = 2;
  localparam int M_W       = 3;
  localparam int WB_W      = 3;
  localparam int ALUOP_W   = 4;
  localparam int FUNCT_W   = 6;
  localparam int M_MEMREAD = 1;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // ex = {RegDst, ALUSrc}; m = {Branch, MemRead, MemWrite}; wb = {Jump, MemToReg, RegWrite}
  typedef struct packed {
    logic [EX_W-1:0]    ex;
    logic [M_W-1:0]     m;
    logic [WB_W-1:0]    wb;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;
  function automatic ctrl_t bubble_ctrl();
    return '0;
  endfunction
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    case (op)
      OP_RTYPE: c = {2'b10, 3'b000, 3'b001, 4'b0010};
      OP_LW:    c = {2'b01, 3'b010, 3'b011, 4'b0000};
      OP_SW:    c = {2'b01, 3'b001, 3'b000, 4'b0000};
      OP_BEQ:   c = {2'b00, 3'b100, 3'b000, 4'b0001};
      OP_ADDI:  c = {2'b01, 3'b000, 3'b001, 4'b0000};
      OP_J:     c = {2'b00, 3'b000, 3'b100, 4'b0000};
      OP_ANDI:  c = {2'b01, 3'b000, 3'b001, 4'b0100};
      OP_ORI:   c = {2'b01, 3'b000, 3'b001, 4'b0101};
      OP_XORI:  c = {2'b01, 3'b000, 3'b001, 4'b0110};
      default:  c = bubble_ctrl();
    endcase
    return c;
  endfunction
  function automatic logic is_logic_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction
endpackage

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// regfile_bypass: 2**ADDR_W x DATA_W register file, r0 hardwired to 0, write-first combinational reads
// ports: clk, rst_n (async active-low clears all entries), we_i/waddr_i/wdata_i write port,
//        raddr1_i/raddr2_i -> rdata1_o/rdata2_o read ports
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    else if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
  // a same-cycle writeback to the addressed register is forwarded so ID never sees stale data
  assign rdata1_o = (raddr1_i == '0) ? '0 : (we_i && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : (we_i && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: MIPS-32 decode stage with register file, immediate/jump generation and ID/EX register
// ports: clk, rst_n (async active-low); IF/ID side instr_in, valid_in, adder_in; writeback reg_write,
//        address_write, data_write; control flush, hold; stall_out back to IF; registered ID/EX
//        outputs valid_out, dato1, dato2, immediate, adder_out, rt_out, rd_out, ex/m/wb/aluop_salida,
//        funct_out, jump_address_out
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter bit ZERO_EXT_LOGIC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_in,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     adder_in,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] address_write,
  input  logic [DATA_W-1:0]     data_write,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     dato1,
  output logic [DATA_W-1:0]     dato2,
  output logic [DATA_W-1:0]     immediate,
  output logic [DATA_W-1:0]     adder_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [EX_W-1:0]       ex_salida,
  output logic [M_W-1:0]        m_salida,
  output logic [WB_W-1:0]       wb_salida,
  output logic [ALUOP_W-1:0]    aluop_salida,
  output logic [FUNCT_W-1:0]    funct_out,
  output logic [DATA_W-1:0]     jump_address_out
);
  localparam int IDEX_W = 1 + 5*DATA_W + 2*REG_ADDR_W + $bits(ctrl_t) + FUNCT_W;
  logic [5:0]            op;
  logic [REG_ADDR_W-1:0] rs_a, rt_a, rd_a;
  logic [DATA_W-1:0]     rs_val, rt_val, imm, jaddr;
  logic                  hazard, bubble;
  logic [IDEX_W-1:0]     idex_d, idex_q;
  assign op   = instr_in[31:26];
  assign rs_a = REG_ADDR_W'(instr_in[25:21]);
  assign rt_a = REG_ADDR_W'(instr_in[20:16]);
  assign rd_a = REG_ADDR_W'(instr_in[15:11]);
  regfile_bypass #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (reg_write),
    .waddr_i  (address_write),
    .wdata_i  (data_write),
    .raddr1_i (rs_a),
    .raddr2_i (rt_a),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val)
  );
  assign imm   = (ZERO_EXT_LOGIC && is_logic_op(op)) ? DATA_W'(instr_in[15:0])
                                                     : {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
  assign jaddr = {adder_in[DATA_W-1:28], instr_in[25:0], 2'b00};
  // load in ID/EX whose destination is read by the instruction now in ID
  assign hazard    = valid_out & m_salida[M_MEMREAD] & (rt_out != '0) & valid_in &
                     ((rt_out == rs_a) | (rt_out == rt_a));
  assign stall_out = hazard & ~flush & ~hold;
  assign bubble    = hazard | ~valid_in;
  assign idex_d = flush ? '0 : hold ? idex_q : bubble ? '0 :
                  {valid_in, rs_val, rt_val, imm, adder_in, jaddr, rt_a, rd_a, decode_ctrl(op), instr_in[5:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idex_q <= '0;
    else idex_q <= idex_d;
  assign {valid_out, dato1, dato2, immediate, adder_out, jump_address_out, rt_out, rd_out,
          ex_salida, m_salida, wb_salida, aluop_salida, funct_out} = idex_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed self-checking bench for decode_stage_pipe
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        valid_in;
  logic [31:0] adder_in;
  logic        reg_write;
  logic [4:0]  address_write;
  logic [31:0] data_write;
  logic        flush, hold;
  logic        stall_out, valid_out;
  logic [31:0] dato1, dato2, immediate, adder_out, jump_address_out;
  logic [4:0]  rt_out, rd_out;
  logic [1:0]  ex_salida;
  logic [2:0]  m_salida, wb_salida;
  logic [3:0]  aluop_salida;
  logic [5:0]  funct_out;
  int total = 0;
  int fails = 0;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .valid_in(valid_in), .adder_in(adder_in),
    .reg_write(reg_write), .address_write(address_write), .data_write(data_write),
    .flush(flush), .hold(hold), .stall_out(stall_out), .valid_out(valid_out),
    .dato1(dato1), .dato2(dato2), .immediate(immediate), .adder_out(adder_out),
    .rt_out(rt_out), .rd_out(rd_out), .ex_salida(ex_salida), .m_salida(m_salida),
    .wb_salida(wb_salida), .aluop_salida(aluop_salida), .funct_out(funct_out),
    .jump_address_out(jump_address_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; instr_in = '0; valid_in = 1'b0; adder_in = '0; reg_write = 1'b0;
    address_write = '0; data_write = '0; flush = 1'b0; hold = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_dato1", dato1, 32'd0);
    rst_n = 1'b1;
    // bypass: write r9 while decoding add r3,r9,r0
    valid_in = 1'b1; adder_in = 32'h0000_1004; instr_in = rtype(5'd9, 5'd0, 5'd3);
    reg_write = 1'b1; address_write = 5'd9; data_write = 32'hDEAD_BEEF;
    tick();
    chk("byp_dato1", dato1, 32'hDEAD_BEEF);
    chk("byp_dato2", dato2, 32'd0);
    chk("byp_valid", {31'd0, valid_out}, 32'd1);
    chk("byp_rd", {27'd0, rd_out}, 32'd3);
    chk("byp_ctrl", {20'd0, ex_salida, m_salida, wb_salida, aluop_salida}, {20'd0, 2'b10, 3'b000, 3'b001, 4'b0010});
    chk("byp_funct", {26'd0, funct_out}, 32'h20);
    chk("byp_adder", adder_out, 32'h0000_1004);
    // write to r0 in the same cycle as reading r0 and r9
    instr_in = rtype(5'd0, 5'd9, 5'd5); address_write = 5'd0; data_write = 32'h1234_5678;
    tick();
    chk("r0_byp_dato1", dato1, 32'd0);
    chk("r9_stored", dato2, 32'hDEAD_BEEF);
    reg_write = 1'b0; instr_in = rtype(5'd0, 5'd0, 5'd6);
    tick();
    chk("r0_unwritten", dato1, 32'd0);
    // load-use: lw r8,4(r1) then add r2,r8,r4
    instr_in = itype(6'h23, 5'd1, 5'd8, 16'h0004);
    #1 chk("lu_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lw_m", {29'd0, m_salida}, 32'b010);
    chk("lw_imm", immediate, 32'd4);
    chk("lw_rt", {27'd0, rt_out}, 32'd8);
    instr_in = rtype(5'd8, 5'd4, 5'd2);
    #1 chk("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, valid_out}, 32'd0);
    chk("lu_bub_ctrl", {20'd0, ex_salida, m_salida, wb_salida, aluop_salida}, 32'd0);
    #1 chk("lu_stall_clear", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, valid_out}, 32'd1);
    chk("lu_add_rd", {27'd0, rd_out}, 32'd2);
    chk("lu_add_wb", {29'd0, wb_salida}, 32'b001);
    // flush beats hazard
    instr_in = itype(6'h23, 5'd1, 5'd8, 16'h0004);
    tick();
    instr_in = rtype(5'd8, 5'd4, 5'd2); flush = 1'b1;
    #1 chk("fl_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, valid_out}, 32'd0);
    chk("fl_m", {29'd0, m_salida}, 32'd0);
    flush = 1'b0;
    // addi sign extension
    instr_in = itype(6'h08, 5'd0, 5'd7, 16'hFFFF);
    tick();
    chk("addi_imm", immediate, 32'hFFFF_FFFF);
    chk("addi_rt", {27'd0, rt_out}, 32'd7);
    // hold beats hazard, outputs frozen for 3 cycles
    instr_in = itype(6'h23, 5'd0, 5'd8, 16'h0010);
    tick();
    hold = 1'b1; instr_in = rtype(5'd8, 5'd4, 5'd2);
    #1 chk("hold_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("hold1_imm", immediate, 32'h10);
    instr_in = itype(6'h0D, 5'd0, 5'd11, 16'h00AA);
    tick();
    chk("hold2_rt", {27'd0, rt_out}, 32'd8);
    instr_in = {6'h02, 26'h3FF_FFFF};
    tick();
    chk("hold3_m", {29'd0, m_salida}, 32'b010);
    chk("hold3_valid", {31'd0, valid_out}, 32'd1);
    chk("hold3_imm", immediate, 32'h10);
    hold = 1'b0; instr_in = itype(6'h0D, 5'd0, 5'd10, 16'hFFFF);
    tick();
    chk("ori_imm", immediate, 32'h0000_FFFF);
    chk("ori_rt", {27'd0, rt_out}, 32'd10);
    chk("ori_alu", {28'd0, aluop_salida}, 32'b0101);
    // jump target, with a writeback of r5 alongside
    instr_in = {6'h02, 26'h010_0000}; adder_in = 32'h4000_0004;
    reg_write = 1'b1; address_write = 5'd5; data_write = 32'h55;
    tick();
    chk("j_addr", jump_address_out, 32'h4040_0000);
    chk("j_adder", adder_out, 32'h4000_0004);
    reg_write = 1'b0; instr_in = rtype(5'd5, 5'd0, 5'd1);
    tick();
    chk("r5_pre_rst", dato1, 32'h55);
    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_dato1", dato1, 32'd0);
    chk("arst_ctrl", {20'd0, ex_salida, m_salida, wb_salida, aluop_salida}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r5_post_rst", dato1, 32'd0);
    chk("post_rst_valid", {31'd0, valid_out}, 32'd1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
